// File: rtl/adder_seq.sv
// adder_seq
//
// Purpose:
//   Multi-cycle WIDTH-bit adder. A single 2-bit carry-chained adder slice is
//   stepped over the operands, least-significant chunk first, one chunk per
//   clock. Holds one transaction at a time, with valid/ready handshakes on
//   both the request side and the result side.
//
// Parameters:
//   WIDTH        operand/sum width, must be even and >= 4 (default 16)
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   io_in_valid  request valid
//   io_in_ready  block can accept a request this cycle
//   io_in_lhs    left operand
//   io_in_rhs    right operand
//   io_in_cin    carry-in
//   io_in_sub    subtract select (only when ADDER_SEQ_SUB_EN is defined)
//   io_out_valid result valid
//   io_out_ready consumer accepts the result
//   io_out_sum   result, modulo 2^WIDTH
//   io_out_cout  carry-out of bit WIDTH-1 (with subtract: 1 = no borrow)
//   io_busy      high while chunks are being processed
//
// Configuration:
//   ADDER_SEQ_SUB_EN  when defined, adds the io_in_sub port; a subtract
//                     latches ~rhs and forces the carry-in to 1.

module adder_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_lhs,
  input  logic [WIDTH-1:0] io_in_rhs,
  input  logic             io_in_cin,
`ifdef ADDER_SEQ_SUB_EN
  input  logic             io_in_sub,
`endif
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_sum,
  output logic             io_out_cout,
  output logic             io_busy
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lhs_q, lhs_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_sum_q, res_sum_d;
  logic             res_cout_q, res_cout_d;

  logic [2:0]       chunk;
  logic [WIDTH-1:0] rhs_load;
  logic             carry_load;
  logic [WIDTH-1:0] sum_next;

  // Operand values as they should be captured on accept. With subtraction
  // enabled, a - b is formed as a + ~b + 1, so the carry-in is overridden.
  always_comb begin
    rhs_load   = io_in_rhs;
    carry_load = io_in_cin;
`ifdef ADDER_SEQ_SUB_EN
    if (io_in_sub) begin
      rhs_load   = ~io_in_rhs;
      carry_load = 1'b1;
    end
`endif
  end

  // The shared 2-bit adder slice and the sum register's next value: the
  // fresh chunk enters at the top so that after WIDTH/2 steps the first
  // chunk has arrived at bits [1:0].
  always_comb begin
    chunk    = 3'(carry_q) + 3'(lhs_q[1:0]) + 3'(rhs_q[1:0]);
    sum_next = {chunk[1:0], sum_q[WIDTH-1:2]};
  end

  // Next-state and datapath control. The result is copied into separate
  // result registers when the last chunk completes, so io_out_sum and
  // io_out_cout stay at the last result while a new transaction runs.
  always_comb begin
    state_d      = state_q;
    lhs_d        = lhs_q;
    rhs_d        = rhs_q;
    carry_d      = carry_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    res_sum_d    = res_sum_q;
    res_cout_d   = res_cout_q;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;
    io_busy      = 1'b0;

    unique case (state_q)
      IDLE: begin
        io_in_ready = 1'b1;
        if (io_in_valid) begin
          lhs_d   = io_in_lhs;
          rhs_d   = rhs_load;
          carry_d = carry_load;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        io_busy = 1'b1;
        sum_d   = sum_next;
        carry_d = chunk[2];
        lhs_d   = {2'b00, lhs_q[WIDTH-1:2]};
        rhs_d   = {2'b00, rhs_q[WIDTH-1:2]};
        if (cnt_q == LAST_CHUNK) begin
          cnt_d      = '0;
          res_sum_d  = sum_next;
          res_cout_d = chunk[2];
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        io_out_valid = 1'b1;
        // A new request may be taken in the same cycle the result leaves.
        io_in_ready  = io_out_ready;
        if (io_out_ready) begin
          if (io_in_valid) begin
            lhs_d   = io_in_lhs;
            rhs_d   = rhs_load;
            carry_d = carry_load;
            sum_d   = '0;
            cnt_d   = '0;
            state_d = BUSY;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      lhs_q      <= '0;
      rhs_q      <= '0;
      carry_q    <= 1'b0;
      sum_q      <= '0;
      cnt_q      <= '0;
      res_sum_q  <= '0;
      res_cout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lhs_q      <= lhs_d;
      rhs_q      <= rhs_d;
      carry_q    <= carry_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      res_sum_q  <= res_sum_d;
      res_cout_q <= res_cout_d;
    end
  end

  assign io_out_sum  = res_sum_q;
  assign io_out_cout = res_cout_q;

endmodule

// File: tb/tb_adder_seq.sv
// tb_adder_seq
//
// Purpose:
//   Self-checking bench for adder_seq at WIDTH=8. Requests are issued by the
//   main process; each accepted request pushes its expected result, derived
//   from plain integer arithmetic, into a queue. An independent monitor pops
//   and compares whenever a result is handed over, and also checks that a
//   stalled result holds steady.
//
// Configuration:
//   ADDER_SEQ_SUB_EN  when defined, subtract cases are exercised as well.

module tb_adder_seq;

  localparam int W    = 8;
  localparam int HALF = W / 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_lhs = '0;
  logic [W-1:0] in_rhs = '0;
  logic         in_cin = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
  logic         in_sub = 1'b0;
`endif
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;

  int check_count = 0;
  int error_count = 0;

  logic [W:0]   exp_q[$];
  logic [W:0]   mon_exp;
  logic         rand_ready = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] hold_sum;
  logic         hold_cout;

  adder_seq #(.WIDTH(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_in_valid  (in_valid),
    .io_in_ready  (in_ready),
    .io_in_lhs    (in_lhs),
    .io_in_rhs    (in_rhs),
    .io_in_cin    (in_cin),
`ifdef ADDER_SEQ_SUB_EN
    .io_in_sub    (in_sub),
`endif
    .io_out_valid (out_valid),
    .io_out_ready (out_ready),
    .io_out_sum   (out_sum),
    .io_out_cout  (out_cout),
    .io_busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [W:0] refModel(input logic [W-1:0] lhs, input logic [W-1:0] rhs,
                                          input logic cin, input logic sub);
    int unsigned a;
    int unsigned b;
    int unsigned t;
    logic [W-1:0] s;
    logic         c;
    a = lhs;
    b = rhs;
    if (sub) begin
      t = a + (1 << W) - b;
      c = (a >= b);
    end else begin
      t = a + b + cin;
      c = (t >= (1 << W));
    end
    s = W'(t % (1 << W));
    return {c, s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Presents a request and holds it until accepted; the expected result is
  // queued on the accepting edge. Called and returns at posedge+1.
  task automatic applyStimulus(input logic [W-1:0] lhs, input logic [W-1:0] rhs,
                               input logic cin, input logic sub, output int waited);
    logic accepted;
    in_lhs   = lhs;
    in_rhs   = rhs;
    in_cin   = cin;
`ifdef ADDER_SEQ_SUB_EN
    in_sub   = sub;
`endif
    in_valid = 1'b1;
    waited   = 0;
    accepted = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      waited++;
    end
    if (!accepted) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL accept_timeout actual=no_ready required=ready at %0t", $time);
    end else begin
      @(posedge clk);
      exp_q.push_back(refModel(lhs, rhs, cin, sub));
    end
    #1;
    in_valid = 1'b0;
    in_lhs   = W'($urandom);
    in_rhs   = W'($urandom);
    in_cin   = 1'($urandom);
  endtask

  // Waits for io_out_valid, counting cycles before it and busy cycles.
  task automatic waitResult(output int lat, output int busy_cycles);
    logic found;
    lat         = 0;
    busy_cycles = 0;
    found       = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      lat++;
      if (busy) busy_cycles++;
    end
    if (!found) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL result_timeout actual=no_valid required=valid at %0t", $time);
    end
  endtask

  // Randomised consumer backpressure during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares handed-over results against the queue and checks that
  // a stalled result does not move.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          checkOutput("hold_valid", 32'(out_valid), 32'd1);
          checkOutput("hold_sum", 32'(out_sum), 32'(hold_sum));
          checkOutput("hold_cout", 32'(out_cout), 32'(hold_cout));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_count++;
            error_count++;
            $display("[TB] FAIL unexpected_result actual=0x%0h required=none at %0t", out_sum, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            checkOutput("result_sum", 32'(out_sum), 32'(mon_exp[W-1:0]));
            checkOutput("result_cout", 32'(out_cout), 32'(mon_exp[W]));
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_sum  = out_sum;
        hold_cout = out_cout;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin : stimulus
    int w;
    int lat;
    int bc;
    int ghost;
    logic [W-1:0] held;
    logic         sub_r;

    #1 reset = 1'b0;
    #11;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] overflow add with latency check");
    out_ready = 1'b1;
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, w);
    waitResult(lat, bc);
    checkOutput("latency", 32'(lat), 32'(HALF));
    checkOutput("busy_cycles", 32'(bc), 32'(HALF));
    @(posedge clk);
    #1;

    $display("[TB] add with carry-in");
    applyStimulus(8'h5A, 8'h33, 1'b1, 1'b0, w);
    waitResult(lat, bc);
    @(posedge clk);
    #1;

    $display("[TB] backpressure and back-to-back accept");
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, w);
    waitResult(lat, bc);
    held = out_sum;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_sum_stable", 32'(out_sum), 32'(held));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, w);
    checkOutput("b2b_accept_wait", 32'(w), 32'd0);
    waitResult(lat, bc);
    checkOutput("b2b_latency", 32'(lat), 32'(HALF));
    @(posedge clk);
    #1;

    $display("[TB] request pulse during busy is ignored");
    applyStimulus(8'h0F, 8'h0F, 1'b0, 1'b0, w);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_lhs   = 8'hAA;
    in_rhs   = 8'h55;
    @(negedge clk);
    checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    waitResult(lat, bc);
    @(posedge clk);
    #1;
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) ghost++;
    end
    checkOutput("no_ghost_result", 32'(ghost), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] reset during busy");
    applyStimulus(8'h77, 8'h11, 1'b0, 1'b0, w);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b0, w);
    waitResult(lat, bc);
    @(posedge clk);
    #1;

`ifdef ADDER_SEQ_SUB_EN
    $display("[TB] subtract cases");
    applyStimulus(8'h10, 8'h01, 1'b0, 1'b1, w);
    waitResult(lat, bc);
    @(posedge clk);
    #1;
    applyStimulus(8'h00, 8'h01, 1'b0, 1'b1, w);
    waitResult(lat, bc);
    @(posedge clk);
    #1;
    applyStimulus(8'h10, 8'h01, 1'b1, 1'b1, w);
    waitResult(lat, bc);
    @(posedge clk);
    #1;
`endif

    $display("[TB] random transactions with random backpressure");
    rand_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sub_r = 1'b0;
`ifdef ADDER_SEQ_SUB_EN
      sub_r = 1'($urandom);
`endif
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom), sub_r, w);
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    @(negedge clk);
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
